// File: rtl/instr_fetch_unit.sv
// Instruction fetch front-end: drives the ROM address, assembles opcode + operand bytes,
// and presents each instruction to decode with a valid/ack handshake.
module instr_fetch_unit #(
  parameter int unsigned                    ROMAddrWidth = 8,
  parameter logic [ROMAddrWidth-1:0]        RESET_VECTOR = '0
) (
  input  logic                    CLK,
  input  logic                    RESET,
  output logic [ROMAddrWidth-1:0] ROM_ADDR,
  input  logic [7:0]              ROM_DATA,
  output logic [7:0]              OPCODE,
  output logic [7:0]              OPERAND,
  output logic [ROMAddrWidth-1:0] INSTR_PC,
  output logic                    INSTR_VALID,
  input  logic                    INSTR_ACK,
  input  logic                    ACK_LEN,
  input  logic                    JUMP_EN,
  input  logic [ROMAddrWidth-1:0] JUMP_ADDR
);

  localparam logic [ROMAddrWidth-1:0] PcStep1 = ROMAddrWidth'(1);
  localparam logic [ROMAddrWidth-1:0] PcStep2 = ROMAddrWidth'(2);

  typedef enum logic [1:0] {StIssue, StOpc, StOpr, StHold} state_e;

  state_e                  state_q;
  logic [ROMAddrWidth-1:0] pc_q;
  logic [ROMAddrWidth-1:0] rom_addr_q;
  logic [ROMAddrWidth-1:0] instr_pc_q;
  logic [7:0]              opcode_q;
  logic [7:0]              operand_q;
  logic                    valid_q;

  logic [ROMAddrWidth-1:0] pc_plus1;
  logic [ROMAddrWidth-1:0] next_pc_d;

  // Sums truncate to the address width, so PC arithmetic wraps naturally.
  always_comb begin
    pc_plus1 = pc_q + PcStep1;
    if (JUMP_EN) begin
      next_pc_d = JUMP_ADDR;
    end else if (ACK_LEN) begin
      next_pc_d = pc_q + PcStep2;
    end else begin
      next_pc_d = pc_plus1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= StIssue;
      pc_q       <= RESET_VECTOR;
      rom_addr_q <= RESET_VECTOR;
      instr_pc_q <= RESET_VECTOR;
      opcode_q   <= 8'h00;
      operand_q  <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIssue: begin
          rom_addr_q <= pc_plus1;
          state_q    <= StOpc;
        end
        StOpc: begin
          opcode_q <= ROM_DATA;
          state_q  <= StOpr;
        end
        StOpr: begin
          operand_q  <= ROM_DATA;
          instr_pc_q <= pc_q;
          valid_q    <= 1'b1;
          state_q    <= StHold;
        end
        StHold: begin
          if (INSTR_ACK) begin
            valid_q    <= 1'b0;
            pc_q       <= next_pc_d;
            rom_addr_q <= next_pc_d;
            state_q    <= StIssue;
          end
        end
        default: state_q <= StIssue;
      endcase
    end
  end

  assign ROM_ADDR    = rom_addr_q;
  assign OPCODE      = opcode_q;
  assign OPERAND     = operand_q;
  assign INSTR_PC    = instr_pc_q;
  assign INSTR_VALID = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a driver predicts each fetched instruction from a
// ROM array and the PC rules; a monitor checks every presented instruction and its timing.
module tb_instr_fetch_unit;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] ROM_ADDR;
  logic [7:0] ROM_DATA;
  logic [7:0] OPCODE;
  logic [7:0] OPERAND;
  logic [7:0] INSTR_PC;
  logic       INSTR_VALID;
  logic       INSTR_ACK = 1'b0;
  logic       ACK_LEN = 1'b0;
  logic       JUMP_EN = 1'b0;
  logic [7:0] JUMP_ADDR = 8'h00;

  instr_fetch_unit #(
    .ROMAddrWidth(8),
    .RESET_VECTOR(8'h00)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .ROM_ADDR   (ROM_ADDR),
    .ROM_DATA   (ROM_DATA),
    .OPCODE     (OPCODE),
    .OPERAND    (OPERAND),
    .INSTR_PC   (INSTR_PC),
    .INSTR_VALID(INSTR_VALID),
    .INSTR_ACK  (INSTR_ACK),
    .ACK_LEN    (ACK_LEN),
    .JUMP_EN    (JUMP_EN),
    .JUMP_ADDR  (JUMP_ADDR)
  );

  always #5 CLK = ~CLK;

  logic [7:0] rom [256];

  // Synchronous ROM with one-cycle read latency.
  always @(posedge CLK) ROM_DATA <= rom[ROM_ADDR];

  typedef struct {
    logic [7:0] pc;
    logic [7:0] opc;
    logic [7:0] opr;
    int         rise;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic       rst_at_edge = 1'b0;
  logic [7:0] model_pc = 8'h00;

  always @(posedge CLK) begin
    cyc++;
    rst_at_edge <= RESET;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(input logic [7:0] pc, input int rise);
    exp_t e;
    logic [7:0] pc1;
    pc1    = pc + 8'd1;
    e.pc   = pc;
    e.opc  = rom[pc];
    e.opr  = rom[pc1];
    e.rise = rise;
    return e;
  endfunction

  // Monitor: pops one prediction per rising INSTR_VALID, then checks outputs stay frozen.
  logic       prev_v = 1'b0;
  logic [7:0] snap_opc, snap_opr, snap_pc, snap_addr;
  always @(negedge CLK) begin
    if (cyc == 0 || rst_at_edge) begin
      prev_v = 1'b0;
    end else begin
      if (INSTR_VALID === 1'b1 && !prev_v) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(INSTR_PC), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          logic [7:0] pc1;
          e = exp_q.pop_front();
          pc1 = e.pc + 8'd1;
          chk("instr_pc", 32'(INSTR_PC), 32'(e.pc));
          chk("opcode", 32'(OPCODE), 32'(e.opc));
          chk("operand", 32'(OPERAND), 32'(e.opr));
          chk("valid_latency", 32'(cyc), 32'(e.rise));
          chk("rom_addr_hold", 32'(ROM_ADDR), 32'(pc1));
        end
        snap_opc  = OPCODE;
        snap_opr  = OPERAND;
        snap_pc   = INSTR_PC;
        snap_addr = ROM_ADDR;
      end else if (INSTR_VALID === 1'b1) begin
        chk("hold_stable", {OPCODE, OPERAND, INSTR_PC, ROM_ADDR},
            {snap_opc, snap_opr, snap_pc, snap_addr});
      end
      prev_v = INSTR_VALID;
    end
  end

  // Called at a negedge; the following posedge is the reset edge.
  task automatic apply_reset(input logic with_ack);
    logic [7:0] one;
    RESET     = 1'b1;
    INSTR_ACK = with_ack;
    ACK_LEN   = 1'($urandom);
    JUMP_EN   = 1'($urandom);
    JUMP_ADDR = 8'($urandom);
    @(posedge CLK);
    #1;
    chk("rst_valid", 32'(INSTR_VALID), 32'h0);
    chk("rst_rom_addr", 32'(ROM_ADDR), 32'h00);
    chk("rst_opcode_operand", {OPCODE, OPERAND}, 32'h0);
    chk("rst_instr_pc", 32'(INSTR_PC), 32'h00);
    @(negedge CLK);
    RESET     = 1'b0;
    INSTR_ACK = 1'b0;
    JUMP_EN   = 1'b0;
    model_pc  = 8'h00;
    exp_q.delete();
    exp_q.push_back(predict(model_pc, cyc + 3));
    one = model_pc + 8'd1;
    @(posedge CLK);
    #1 chk("issue_rom_addr", 32'(ROM_ADDR), 32'(one));
    @(posedge CLK);
    #1 chk("opc_rom_addr", 32'(ROM_ADDR), 32'(one));
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (INSTR_VALID !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    ok = (INSTR_VALID === 1'b1);
    if (!ok) chk("valid_timeout", 32'(INSTR_VALID), 32'h1);
  endtask

  // Waits for a presented instruction, stalls for `delay` cycles with noise on the
  // ignored inputs, then accepts it; returns at the negedge before the accepting edge.
  task automatic accept(input logic len, input logic jmp, input logic [7:0] addr,
                        input int delay);
    bit         ok;
    logic [7:0] nxt;
    @(negedge CLK);
    INSTR_ACK = 1'b0;
    JUMP_EN   = 1'b0;
    wait_valid(ok);
    if (!ok) return;
    for (int i = 0; i < delay; i++) begin
      JUMP_EN   = 1'($urandom);
      ACK_LEN   = 1'($urandom);
      JUMP_ADDR = 8'($urandom);
      @(negedge CLK);
    end
    INSTR_ACK = 1'b1;
    ACK_LEN   = len;
    JUMP_EN   = jmp;
    JUMP_ADDR = addr;
    nxt = jmp ? addr : (len ? model_pc + 8'd2 : model_pc + 8'd1);
    model_pc = nxt;
    exp_q.push_back(predict(nxt, cyc + 4));
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h00] = 8'hA1;
    rom[8'h01] = 8'h3C;
    rom[8'hFF] = 8'h11;

    @(negedge CLK);
    apply_reset(1'b0);

    accept(1'b1, 1'b0, 8'h00, 0);   // 00 -> 02
    accept(1'b0, 1'b0, 8'h00, 1);   // 02 -> 03
    accept(1'b1, 1'b1, 8'h80, 2);   // jump -> 80
    accept(1'b0, 1'b0, 8'h00, 10);  // backpressure with JUMP_EN noise, 80 -> 81
    rom[8'h00] = 8'h22;
    accept(1'b0, 1'b1, 8'hFF, 0);   // jump -> FF, operand wraps to 00
    accept(1'b1, 1'b0, 8'h00, 1);   // FF + 2 wraps to 01

    for (int k = 0; k < 40; k++) begin
      accept(1'($urandom), ($urandom_range(0, 3) == 0), 8'($urandom), $urandom_range(0, 4));
    end

    // Reset while the opcode byte is being captured.
    @(negedge CLK);
    INSTR_ACK = 1'b0;
    JUMP_EN   = 1'b0;
    @(negedge CLK);
    apply_reset(1'b0);
    accept(1'b1, 1'b0, 8'h00, 0);

    // Reset in HOLD coinciding with an ack.
    @(negedge CLK);
    INSTR_ACK = 1'b0;
    JUMP_EN   = 1'b0;
    wait_valid(ok);
    apply_reset(1'b1);
    for (int k = 0; k < 5; k++) begin
      accept(1'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom), $urandom_range(0, 3));
    end

    @(negedge CLK);
    INSTR_ACK = 1'b0;
    JUMP_EN   = 1'b0;
    repeat (6) @(negedge CLK);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
